async_event_arbiter: RTL

Collects rising-edge events from N asynchronous input lines, synchronizes each through a brute-force flip-flop chain, and latches it as a pending event. It then serves pending events one at a time to a single downstream consumer through a valid/ack handshake, using round-robin arbitration. It sits at the boundary between off-chip or foreign-clock status lines and the core's event and interrupt logic, so each async line needs no synchronizer or edge detector of its own.

---
 rtl/async_event_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/async_event_arbiter.sv
// async_event_arbiter: synchronizes N async lines, latches rising edges as
// pending events and offers them one at a time, round-robin, over valid/ack.
//   clk, rst          : clock, synchronous active-high reset
//   async_in[N]       : asynchronous level inputs, bit i = requester i
//   evt_valid/evt_id  : registered offer of one requester index
//   evt_ack           : consumer accepts the offer (ignored when not valid)
//   pending[N]        : latched, unserved events
//   overflow[N]       : sticky, event arrived while one was already pending
module async_event_arbiter #(
  parameter int N = 4,
  parameter int SYNC_STAGES = 3,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    async_in,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ack,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow
);

  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM = WW'(SYNC_STAGES + 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N-1:0]    r_sync [SYNC_STAGES];
  logic [N-1:0]    r_prev;
  logic [N-1:0]    r_pending;
  logic [N-1:0]    r_overflow;
  logic [WW-1:0]   r_warm;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_last;
  state_t          r_state;

  state_t          w_state_nxt;
  logic [ID_W-1:0] w_id_nxt;
  logic [ID_W-1:0] w_last_nxt;
  logic [ID_W-1:0] w_pick;
  logic            w_found;
  int              w_idx;
  logic [N-1:0]    w_sync;
  logic [N-1:0]    w_rise;
  logic [N-1:0]    w_clr;
  logic            w_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        r_sync[s] <= '0;
    end else begin
      r_sync[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // After reset the zeroed chain refills with the live input levels; the
  // warm-up window hides that artificial 0->1 so a line already high at
  // release does not look like a new event.
  assign w_rise = (r_warm == '0) ? (w_sync & ~r_prev) : '0;

  assign w_acc = (r_state == OFFER) & evt_ack;
  assign w_clr = w_acc ? (ONE << r_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_overflow <= '0;
      r_warm     <= WARM;
    end else begin
      r_prev     <= w_sync;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_overflow <= r_overflow | (w_rise & r_pending & ~w_clr);
      if (r_warm != '0)
        r_warm <= r_warm - 1'b1;
    end
  end

  // First pending requester after the last one served, wrapping mod N.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_last) + k) % N;
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_id_nxt    = w_pick;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ack) begin
          w_last_nxt  = r_id;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_last  <= ID_W'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign evt_valid = (r_state == OFFER);
  assign evt_id    = r_id;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
